// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the ID-stage control decode and the hazard controller.
//   OP_*           : primary opcodes the hazard logic needs to recognise
//   hz_state_t     : hazard controller states (RUN=0, STALL=1, FLUSH=2; 3 unused)
//   REG_ZERO       : $zero register number, never a real producer
//   op_uses_rt()   : 1 when the opcode reads rt as a source operand
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_t;

    // lw only reads rs (base); its rt is a destination, so it cannot
    // create a hazard through rt.
    function automatic logic op_uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/hz_regmatch.sv
// hz_regmatch: combinational load-use hazard detect.
//   ex_memread : instruction in EX is a load
//   ex_rt      : load destination register
//   id_rs      : rs of instruction in ID
//   id_rt      : rt of instruction in ID
//   uses_rt    : instruction in ID reads rt
//   haz        : 1 = ID needs the load result that is not yet available
module hz_regmatch
    import mips_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rt,
    output logic       haz
);

    // A load into $zero produces nothing, so it never stalls.
    assign haz = ex_memread && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage sequencer for load-use stalls and taken-branch flushes.
// Optional build macro: HAZ_STATS_EN (adds saturating stall/flush cycle counters;
// when undefined the counter outputs read 0 and no counter flops exist).
// Parameters:
//   LOAD_STALLS (1..3) bubbles per load-use hazard
//   BR_SHADOW   (0..3) extra ifid_flush cycles after a taken branch
// Ports:
//   clk, reset (async, active-low)
//   id_opcode/id_rs/id_rt           : instruction in ID
//   ex_memread/ex_rt                : load in EX
//   mem_branch_taken                : beq in MEM resolved taken
//   pc_write, ifid_write            : pipeline front-end enables
//   ifid_flush, idex_bubble         : nop insertion controls
//   hz_state                        : current state
//   stall_cnt, flush_cnt            : statistics (HAZ_STATS_EN only)
module id_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int LOAD_STALLS = 1,
    parameter int BR_SHADOW   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALLS - 1);
    localparam logic [1:0] SHADOW_LOAD = 2'(BR_SHADOW);

    hz_state_t  state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       haz;

    hz_regmatch u_regmatch (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .uses_rt    (op_uses_rt(id_opcode)),
        .haz        (haz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_next  = state_reg;
        cnt_next    = cnt_reg;

        if (mem_branch_taken && (state_reg == HZ_RUN || state_reg == HZ_STALL ||
                                 state_reg == HZ_FLUSH)) begin
            // A taken branch wins in every legal state: it kills the wrong-path
            // instructions in IF/ID and ID and abandons any stall in progress.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (BR_SHADOW > 0) begin
                state_next = HZ_FLUSH;
                cnt_next   = SHADOW_LOAD;
            end else begin
                state_next = HZ_RUN;
                cnt_next   = 2'd0;
            end
        end else begin
            unique case (state_reg)
                HZ_RUN: begin
                    if (haz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            state_next = HZ_STALL;
                            cnt_next   = STALL_LOAD;
                        end
                    end
                end
                HZ_STALL: begin
                    // The load has moved on; the remaining bubbles are purely
                    // counted, haz is not looked at again.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_next    = cnt_reg - 2'd1;
                    if (cnt_reg <= 2'd1) begin
                        state_next = HZ_RUN;
                        cnt_next   = 2'd0;
                    end
                end
                HZ_FLUSH: begin
                    // ID holds a flushed nop, so load hazards are irrelevant here.
                    ifid_flush = 1'b1;
                    cnt_next   = cnt_reg - 2'd1;
                    if (cnt_reg <= 2'd1) begin
                        state_next = HZ_RUN;
                        cnt_next   = 2'd0;
                    end
                end
                default: begin
                    state_next = HZ_RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end

        // Hold the pipeline frozen and filled with nops while reset is low.
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign hz_state = state_reg;

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;
    logic        stall_evt;

    // A bubble without a flush can only come from a load-use stall; branch
    // bubbles always come with ifid_flush.
    assign stall_evt = reset && idex_bubble && !ifid_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 16'h0000;
            flush_cnt_reg <= 16'h0000;
        end else begin
            if (stall_evt && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (ifid_flush && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed bench for id_hazard_ctrl.
// Three instances share one stimulus stream:
//   dut_a LOAD_STALLS=1 BR_SHADOW=0, dut_b LOAD_STALLS=2 BR_SHADOW=2,
//   dut_c LOAD_STALLS=2 BR_SHADOW=0.
// Each cycle the expected {pc_write,ifid_write,ifid_flush,idex_bubble,hz_state}
// of every instance is queued with the stimulus and checked mid-cycle.
module tb_id_hazard_ctrl;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LD = 6'b100011;
    localparam logic [5:0] OP_ST = 6'b101011;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, hz_state[1:0]}
    localparam logic [5:0] NORM = 6'b1100_00;
    localparam logic [5:0] STL  = 6'b0001_00;  // hazard seen in RUN
    localparam logic [5:0] STS  = 6'b0001_01;  // counted stall in STALL
    localparam logic [5:0] BRR  = 6'b1111_00;  // branch taken in RUN
    localparam logic [5:0] BRS  = 6'b1111_01;  // branch taken in STALL
    localparam logic [5:0] BRF  = 6'b1111_10;  // branch taken in FLUSH
    localparam logic [5:0] FLS  = 6'b1110_10;  // shadow flush
    localparam logic [5:0] RST  = 6'b0011_00;  // held in reset

    typedef struct {
        string      tag;
        logic [5:0] ea;
        logic [5:0] eb;
        logic [5:0] ec;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_memread, mem_branch_taken;

    logic        pw_a, iw_a, fl_a, bb_a, pw_b, iw_b, fl_b, bb_b, pw_c, iw_c, fl_c, bb_c;
    logic [1:0]  st_a, st_b, st_c;
    logic [15:0] sc_a, fc_a, sc_b, fc_b, sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.LOAD_STALLS(1), .BR_SHADOW(0)) dut_a (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(fl_a), .idex_bubble(bb_a),
        .hz_state(st_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    id_hazard_ctrl #(.LOAD_STALLS(2), .BR_SHADOW(2)) dut_b (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(fl_b), .idex_bubble(bb_b),
        .hz_state(st_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    id_hazard_ctrl #(.LOAD_STALLS(2), .BR_SHADOW(0)) dut_c (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .pc_write(pw_c), .ifid_write(iw_c), .ifid_flush(fl_c), .idex_bubble(bb_c),
        .hz_state(st_c), .stall_cnt(sc_c), .flush_cnt(fc_c)
    );

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check6(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at posedge+1, queue expectations, compare at negedge.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                       input logic br, input logic [5:0] ea, input logic [5:0] eb,
                       input logic [5:0] ec);
        exp_t e;
        id_opcode        = op;
        id_rs            = rs;
        id_rt            = rt;
        ex_memread       = mr;
        ex_rt            = ert;
        mem_branch_taken = br;
        e.tag = tag; e.ea = ea; e.eb = eb; e.ec = ec;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check6({e.tag, "_a"}, {pw_a, iw_a, fl_a, bb_a, st_a}, e.ea);
        check6({e.tag, "_b"}, {pw_b, iw_b, fl_b, bb_b, st_b}, e.eb);
        check6({e.tag, "_c"}, {pw_c, iw_c, fl_c, bb_c, st_c}, e.ec);
        $display("cycle %-10s a=%b b=%b c=%b", e.tag, {pw_a, iw_a, fl_a, bb_a, st_a},
                 {pw_b, iw_b, fl_b, bb_b, st_b}, {pw_c, iw_c, fl_c, bb_c, st_c});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                        input logic [5:0] ec);
        cyc(tag, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ea, eb, ec);
    endtask

    initial begin
        reset = 1'b0;
        id_opcode = OP_R; id_rs = 0; id_rt = 0; ex_memread = 0; ex_rt = 0; mem_branch_taken = 0;
        #1;

        // Reset held, even with a hazard and a branch presented.
        idle("rst0", RST, RST, RST);
        cyc("rst1", OP_R, 5'd2, 5'd2, 1'b1, 5'd2, 1'b1, RST, RST, RST);
        idle("rst2", RST, RST, RST);
        check16("rst_stall_b", sc_b, 16'h0000);
        check16("rst_flush_b", fc_b, 16'h0000);
        reset = 1'b1;
        idle("rel0", NORM, NORM, NORM);

        // lw $2 in EX, add $2,$2,$2 in ID
        cyc("t2_haz", OP_R, 5'd2, 5'd2, 1'b1, 5'd2, 1'b0, STL, STL, STL);
        idle("t2_s1", NORM, STS, STS);
        idle("t2_s2", NORM, NORM, NORM);
`ifdef HAZ_STATS_EN
        check16("t2_stall_a", sc_a, 16'd1);
        check16("t2_stall_b", sc_b, 16'd2);
`else
        check16("t2_stall_a", sc_a, 16'd0);
        check16("t2_stall_b", sc_b, 16'd0);
`endif

        // rt use depends on opcode; $zero and non-loads never stall
        cyc("t3_sw", OP_ST, 5'd4, 5'd2, 1'b1, 5'd2, 1'b0, STL, STL, STL);
        idle("t3_sw1", NORM, STS, STS);
        idle("t3_sw2", NORM, NORM, NORM);
        cyc("t3_lwrt", OP_LD, 5'd4, 5'd2, 1'b1, 5'd2, 1'b0, NORM, NORM, NORM);
        cyc("t3_zero", OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, NORM, NORM, NORM);
        cyc("t3_nomr", OP_R, 5'd2, 5'd2, 1'b0, 5'd2, 1'b0, NORM, NORM, NORM);
        cyc("t3_lwrs", OP_LD, 5'd2, 5'd7, 1'b1, 5'd2, 1'b0, STL, STL, STL);
        idle("t3_rs1", NORM, STS, STS);
        idle("t3_rs2", NORM, NORM, NORM);

        // branch taken during a stall aborts it
        cyc("t4_haz", OP_R, 5'd2, 5'd2, 1'b1, 5'd2, 1'b0, STL, STL, STL);
        cyc("t4_br", OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, BRR, BRS, BRS);
        idle("t4_a1", NORM, FLS, NORM);
        idle("t4_a2", NORM, FLS, NORM);
        idle("t4_a3", NORM, NORM, NORM);

        // single branch pulse: shadow of BR_SHADOW cycles
        cyc("t5_br", OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, BRR, BRR, BRR);
        idle("t5_f1", NORM, FLS, NORM);
        idle("t5_f2", NORM, FLS, NORM);
        idle("t5_f3", NORM, NORM, NORM);

        // second branch inside the shadow reloads it
        cyc("t5r_br", OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, BRR, BRR, BRR);
        idle("t5r_f1", NORM, FLS, NORM);
        cyc("t5r_br2", OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, BRR, BRF, BRR);
        idle("t5r_f2", NORM, FLS, NORM);
        idle("t5r_f3", NORM, FLS, NORM);
        idle("t5r_f4", NORM, NORM, NORM);

        // branch and hazard together: branch wins
        cyc("t6_both", OP_R, 5'd2, 5'd2, 1'b1, 5'd2, 1'b1, BRR, BRR, BRR);
        idle("t6_f1", NORM, FLS, NORM);
        idle("t6_f2", NORM, FLS, NORM);
        idle("t6_f3", NORM, NORM, NORM);

`ifdef HAZ_STATS_EN
        check16("cnt_stall_a", sc_a, 16'd4);
        check16("cnt_stall_b", sc_b, 16'd7);
        check16("cnt_stall_c", sc_c, 16'd7);
        check16("cnt_flush_a", fc_a, 16'd5);
        check16("cnt_flush_b", fc_b, 16'd14);
        check16("cnt_flush_c", fc_c, 16'd5);

        // continuous hazard long enough to saturate every stall counter
        id_opcode = OP_R; id_rs = 5'd3; id_rt = 5'd3; ex_memread = 1'b1; ex_rt = 5'd3;
        mem_branch_taken = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check16("sat_stall_a", sc_a, 16'hFFFF);
        check16("sat_stall_b", sc_b, 16'hFFFF);
        check16("sat_stall_c", sc_c, 16'hFFFF);
        check16("sat_flush_a", fc_a, 16'd5);
`else
        check16("nostats_sa", sc_a, 16'h0000);
        check16("nostats_fa", fc_a, 16'h0000);
        check16("nostats_sb", sc_b, 16'h0000);
        check16("nostats_fb", fc_b, 16'h0000);
        check16("nostats_sc", sc_c, 16'h0000);
        check16("nostats_fc", fc_c, 16'h0000);
`endif

        // asynchronous reset mid-cycle forces the outputs immediately
        reset = 1'b0;
        #1;
        check6("async_rst_a", {pw_a, iw_a, fl_a, bb_a, st_a}, RST);
        check16("async_rst_sb", sc_b, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
